// File: rtl/sisc_mem_resp.sv
// sisc_mem_resp: word-wide memory responder with programmable wait states
// and a req/ack handshake for the SISC multi-cycle controller.
module sisc_mem_resp #(
    parameter int unsigned AW    = 16,
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 256,
    parameter int unsigned WAIT  = 2
) (
    input  logic          clk,
    input  logic          rst_f,
    input  logic          req,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          ack,
    output logic          busy,
    output logic          err
);

    localparam int unsigned CW = 4;
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_n;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_n;
    logic            r_we;
    logic            w_we_n;
    logic [AW-1:0]   r_addr;
    logic [AW-1:0]   w_addr_n;
    logic [DW-1:0]   r_wdata;
    logic [DW-1:0]   w_wdata_n;
    logic [DW-1:0]   r_rdata;
    logic [DW-1:0]   w_rdata_n;
    logic            r_ack;
    logic            w_ack_n;
    logic            r_busy;
    logic            w_busy_n;
    logic            r_err;
    logic            w_err_n;
    logic            w_rng_n;
    logic            w_wr_en;

    // Word storage; deliberately not reset so contents survive rst_f.
    logic [DW-1:0]   r_mem [DEPTH];

    assign rdata = r_rdata;
    assign ack   = r_ack;
    assign busy  = r_busy;
    assign err   = r_err;

    // Range check on the address the next cycle will hold (live in IDLE, latched otherwise).
    assign w_rng_n = (32'(w_addr_n) < DEPTH);

    // Commit the write on the edge that leaves ACK; reset forces IDLE and discards it.
    assign w_wr_en = (r_state == S_ACK) && r_we && (32'(r_addr) < DEPTH);

    // State, latched request and registered outputs.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_we    <= w_we_n;
            r_addr  <= w_addr_n;
            r_wdata <= w_wdata_n;
            r_rdata <= w_rdata_n;
            r_ack   <= w_ack_n;
            r_busy  <= w_busy_n;
            r_err   <= w_err_n;
        end
    end

    // Next state, request latch, wait counter and next output values.
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_we_n    = r_we;
        w_addr_n  = r_addr;
        w_wdata_n = r_wdata;
        w_rdata_n = r_rdata;

        case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_we_n    = we;
                    w_addr_n  = addr;
                    w_wdata_n = wdata;
                    w_cnt_n   = CW'(WAIT);
                    w_state_n = (WAIT == 0) ? S_ACK : S_WAIT;
                end
            end
            S_WAIT: begin
                w_cnt_n = r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    w_state_n = S_ACK;
                end
            end
            S_ACK: begin
                w_state_n = S_IDLE;
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase

        w_ack_n  = (w_state_n == S_ACK);
        w_busy_n = (w_state_n != S_IDLE);
        w_err_n  = w_ack_n && !w_rng_n;

        // Read data is captured on entry to ACK; writes leave it untouched.
        if (r_state != S_ACK && w_state_n == S_ACK && !w_we_n) begin
            w_rdata_n = w_rng_n ? r_mem[w_addr_n[IW-1:0]] : '0;
        end
    end

    // Array write port.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_addr[IW-1:0]] <= r_wdata;
        end
    end

endmodule

// File: tb/tb_sisc_mem_resp.sv
// Directed self-checking bench for sisc_mem_resp (WAIT = 2 and WAIT = 0 instances).
module tb_sisc_mem_resp;

    logic        clk;
    logic        rst_f;

    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic        busy;
    logic        err;

    logic        req0;
    logic        we0;
    logic [15:0] addr0;
    logic [31:0] wdata0;
    logic [31:0] rdata0;
    logic        ack0;
    logic        busy0;
    logic        err0;

    int unsigned n_chk;
    int unsigned n_pass;

    sisc_mem_resp #(.AW(16), .DW(32), .DEPTH(256), .WAIT(2)) dut (
        .clk   (clk),
        .rst_f (rst_f),
        .req   (req),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .ack   (ack),
        .busy  (busy),
        .err   (err)
    );

    sisc_mem_resp #(.AW(16), .DW(32), .DEPTH(256), .WAIT(0)) dut0 (
        .clk   (clk),
        .rst_f (rst_f),
        .req   (req0),
        .we    (we0),
        .addr  (addr0),
        .wdata (wdata0),
        .rdata (rdata0),
        .ack   (ack0),
        .busy  (busy0),
        .err   (err0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count one comparison and report it if it differs.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst_f  = 1'b0;
        req    = 1'b0;
        we     = 1'b0;
        addr   = '0;
        wdata  = '0;
        req0   = 1'b0;
        we0    = 1'b0;
        addr0  = '0;
        wdata0 = '0;

        dut.r_mem[3]   = 32'hDEAD_BEEF;
        dut.r_mem[5]   = 32'h5555_5555;
        dut.r_mem[7]   = 32'h7777_7777;
        dut.r_mem[10]  = 32'h0000_0000;
        dut.r_mem[44]  = 32'h4444_4444;
        dut0.r_mem[0]  = 32'hA0A0_A0A0;

        step();
        step();
        chk("rst_ack",   32'(ack),  32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_err",   32'(err),  32'd0);
        chk("rst_rdata", rdata,     32'd0);
        rst_f = 1'b1;
        step();

        // Read latency with WAIT = 2
        req = 1'b1; we = 1'b0; addr = 16'd3;
        step();
        chk("rd_c1_busy", 32'(busy), 32'd1);
        chk("rd_c1_ack",  32'(ack),  32'd0);
        step();
        chk("rd_c2_ack",  32'(ack),  32'd0);
        chk("rd_c2_busy", 32'(busy), 32'd1);
        step();
        chk("rd_c3_ack",   32'(ack),  32'd1);
        chk("rd_c3_busy",  32'(busy), 32'd1);
        chk("rd_c3_rdata", rdata,     32'hDEAD_BEEF);
        chk("rd_c3_err",   32'(err),  32'd0);
        req = 1'b0;
        step();
        chk("rd_c4_ack",   32'(ack),  32'd0);
        chk("rd_c4_busy",  32'(busy), 32'd0);
        chk("rd_hold",     rdata,     32'hDEAD_BEEF);

        // Write then back-to-back read of the same address
        req = 1'b1; we = 1'b1; addr = 16'd10; wdata = 32'h0000_1234;
        step();
        step();
        step();
        chk("wr_ack",      32'(ack), 32'd1);
        chk("wr_err",      32'(err), 32'd0);
        chk("wr_rdata_kp", rdata,    32'hDEAD_BEEF);
        we = 1'b0; wdata = 32'h0;
        step();
        chk("b2b_idle_ack",  32'(ack),  32'd0);
        chk("b2b_idle_busy", 32'(busy), 32'd0);
        chk("wr_mem10",      dut.r_mem[10], 32'h0000_1234);
        step();
        chk("b2b_acc_busy", 32'(busy), 32'd1);
        step();
        chk("b2b_c2_ack", 32'(ack), 32'd0);
        step();
        chk("b2b_ack",   32'(ack), 32'd1);
        chk("b2b_rdata", rdata,    32'h0000_1234);
        req = 1'b0;
        step();

        // Out-of-range write then read
        req = 1'b1; we = 1'b1; addr = 16'd300; wdata = 32'hFFFF_FFFF;
        step(); step(); step();
        chk("oor_wr_ack",   32'(ack), 32'd1);
        chk("oor_wr_err",   32'(err), 32'd1);
        chk("oor_wr_rdata", rdata,    32'h0000_1234);
        req = 1'b0; we = 1'b0;
        step();
        chk("oor_err_fall", 32'(err), 32'd0);
        chk("oor_mem44",    dut.r_mem[44], 32'h4444_4444);
        req = 1'b1; we = 1'b0; addr = 16'd300;
        step(); step(); step();
        chk("oor_rd_ack",   32'(ack), 32'd1);
        chk("oor_rd_err",   32'(err), 32'd1);
        chk("oor_rd_rdata", rdata,    32'd0);
        req = 1'b0;
        step();

        // Inputs ignored while waiting: latched address, no extra ack, no stray write
        req = 1'b1; we = 1'b0; addr = 16'd3; wdata = 32'h0BAD_F00D;
        step();
        addr = 16'd7; we = 1'b1; req = 1'b0;
        step();
        req = 1'b1;
        step();
        chk("ign_ack",   32'(ack), 32'd1);
        chk("ign_rdata", rdata,    32'hDEAD_BEEF);
        req = 1'b0; we = 1'b0;
        step();
        chk("ign_ack_c1", 32'(ack), 32'd0);
        step();
        step();
        chk("ign_ack_c3",  32'(ack),  32'd0);
        chk("ign_busy_c3", 32'(busy), 32'd0);
        chk("ign_mem7",    dut.r_mem[7], 32'h7777_7777);
        chk("ign_mem3",    dut.r_mem[3], 32'hDEAD_BEEF);

        // Reset in the middle of a write to address 5
        req = 1'b1; we = 1'b1; addr = 16'd5; wdata = 32'hBAD0_BAD0;
        step();
        step();
        chk("mid_busy_pre", 32'(busy), 32'd1);
        req = 1'b0; we = 1'b0;
        rst_f = 1'b0;
        #1;
        chk("mid_rst_ack",   32'(ack),  32'd0);
        chk("mid_rst_busy",  32'(busy), 32'd0);
        chk("mid_rst_err",   32'(err),  32'd0);
        chk("mid_rst_rdata", rdata,     32'd0);
        step(); step(); step();
        chk("mid_rst_mem5", dut.r_mem[5], 32'h5555_5555);
        rst_f = 1'b1;
        step();
        chk("post_rst_busy", 32'(busy), 32'd0);
        req = 1'b1; we = 1'b0; addr = 16'd5;
        step();
        chk("post_rst_acc", 32'(busy), 32'd1);
        step(); step();
        chk("post_rst_ack",   32'(ack), 32'd1);
        chk("post_rst_rdata", rdata,    32'h5555_5555);
        req = 1'b0;
        step();

        // WAIT = 0: ack in the cycle right after acceptance, then a mandatory IDLE
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'd0;
        step();
        chk("w0_ack",   32'(ack0),  32'd1);
        chk("w0_busy",  32'(busy0), 32'd1);
        chk("w0_rdata", rdata0,     32'hA0A0_A0A0);
        chk("w0_err",   32'(err0),  32'd0);
        req0 = 1'b0;
        step();
        chk("w0_ack_fall",  32'(ack0),  32'd0);
        chk("w0_busy_fall", 32'(busy0), 32'd0);
        chk("w0_rdata_hold", rdata0,    32'hA0A0_A0A0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
